hit_result_collector: RTL and testbench

Downstream consumer of the ray-traversal core's hit results. Accepts per-ray closest-hit reports (ray id, hitT, triangle id) and keeps the minimum hitT per ray in an internal result RAM. When the core signals completion, it streams the final per-ray table out over a valid/ready port for write-back or checking. Also counts accepted hits, dropped reports and busy cycles for performance readout.

---
 rtl/hit_result_collector.sv | 134 +++++++++++++
 tb/tb_hit_result_collector.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hit_result_collector.sv
// hit_result_collector: keeps per-ray min hitT/triangle in a RAM, then drains the table over valid/ready with perf counters
module hit_result_collector #(
  parameter int RAY_NUM = 1024,
  parameter int ID_W = 10,
  parameter logic [31:0] HITT_INF = 32'h7F800000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [31:0]     io_in_ray_id,
  input  logic [31:0]     io_in_hitT,
  input  logic [31:0]     io_in_tri_id,
  input  logic            io_rtp_finish,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [ID_W-1:0] io_out_ray_id,
  output logic [31:0]     io_out_hitT,
  output logic [31:0]     io_out_tri_id,
  output logic            io_out_last,
  output logic [31:0]     io_hit_count,
  output logic [31:0]     io_drop_count,
  output logic [63:0]     io_cycles,
  output logic            io_done
);
  typedef enum logic [2:0] {CLEAR, COLLECT, FLUSH, DRAIN, DONE} state_t;
  localparam logic [ID_W:0] LAST = (ID_W+1)'(RAY_NUM-1);
  state_t state_q, state_d;
  logic [ID_W:0] cnt_q, cnt_d;
  logic [63:0] mem [RAY_NUM];
  logic [63:0] rd_q;
  logic re, we, hs, bad, adv, issue, upd;
  logic [ID_W-1:0] raddr, waddr;
  logic [63:0] wdata, old_e, new_e;
  logic s2_v_q, s2_v_d, fw_v_q, fw_v_d, ov_q, ov_d, last_q, last_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d, fw_id_q, fw_id_d, oid_q, oid_d;
  logic [63:0] s2_e_q, s2_e_d, fw_e_q, fw_e_d;
  logic [31:0] hit_q, hit_d, drop_q, drop_d;
  logic [63:0] cyc_q, cyc_d;
  always_comb begin
    hs = state_q == COLLECT && io_in_valid;
    bad = io_in_ray_id >= 32'(RAY_NUM) || io_in_hitT[31];
    old_e = fw_v_q && fw_id_q == s2_id_q ? fw_e_q : rd_q;
    upd = s2_v_q && s2_e_q[63:32] < old_e[63:32];
    new_e = upd ? s2_e_q : old_e;
    adv = !ov_q || io_out_ready;
    issue = state_q == DRAIN && adv && !cnt_q[ID_W];
    re = state_q == COLLECT || issue;
    raddr = state_q == COLLECT ? io_in_ray_id[ID_W-1:0] : cnt_q[ID_W-1:0];
    we = state_q == CLEAR || upd;
    waddr = state_q == CLEAR ? cnt_q[ID_W-1:0] : s2_id_q;
    wdata = state_q == CLEAR ? {HITT_INF, 32'hFFFFFFFF} : s2_e_q;
    s2_v_d = hs && !bad;
    s2_id_d = io_in_ray_id[ID_W-1:0];
    s2_e_d = {io_in_hitT, io_in_tri_id};
    fw_v_d = s2_v_q;
    fw_id_d = s2_id_q;
    fw_e_d = new_e;
    hit_d = hs && !bad && !(&hit_q) ? hit_q + 32'd1 : hit_q;
    drop_d = hs && bad && !(&drop_q) ? drop_q + 32'd1 : drop_q;
    cyc_d = state_q == COLLECT && !(&cyc_q) ? cyc_q + 64'd1 : cyc_q;
    ov_d = issue || (ov_q && !io_out_ready);
    oid_d = issue ? cnt_q[ID_W-1:0] : oid_q;
    last_d = issue ? cnt_q == LAST : last_q;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      CLEAR: begin
        state_d = cnt_q == LAST ? COLLECT : CLEAR;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      end
      COLLECT: state_d = io_rtp_finish ? FLUSH : COLLECT;
      FLUSH: begin
        state_d = cnt_q[0] ? DRAIN : FLUSH;
        cnt_d = cnt_q[0] ? '0 : cnt_q + 1'b1;
      end
      DRAIN: begin
        state_d = ov_q && io_out_ready && last_q ? DONE : DRAIN;
        cnt_d = issue ? cnt_q + 1'b1 : cnt_q;
      end
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clock) begin
    if (reset) rd_q <= '0;
    else if (re) rd_q <= mem[raddr];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      s2_v_q <= 1'b0;
      s2_id_q <= '0;
      s2_e_q <= '0;
      fw_v_q <= 1'b0;
      fw_id_q <= '0;
      fw_e_q <= '0;
      ov_q <= 1'b0;
      oid_q <= '0;
      last_q <= 1'b0;
      hit_q <= '0;
      drop_q <= '0;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s2_v_q <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_e_q <= s2_e_d;
      fw_v_q <= fw_v_d;
      fw_id_q <= fw_id_d;
      fw_e_q <= fw_e_d;
      ov_q <= ov_d;
      oid_q <= oid_d;
      last_q <= last_d;
      hit_q <= hit_d;
      drop_q <= drop_d;
      cyc_q <= cyc_d;
    end
  end
  assign io_in_ready = state_q == COLLECT;
  assign io_out_valid = ov_q;
  assign io_out_ray_id = oid_q;
  assign io_out_hitT = rd_q[63:32];
  assign io_out_tri_id = rd_q[31:0];
  assign io_out_last = last_q;
  assign io_hit_count = hit_q;
  assign io_drop_count = drop_q;
  assign io_cycles = cyc_q;
  assign io_done = state_q == DONE;
endmodule

// File: tb/tb_hit_result_collector.sv
// tb_hit_result_collector: randomized reports checked against a per-ray minimum table model
module tb_hit_result_collector;
  localparam int N = 1024;
  localparam int IDW = 10;
  logic clock = 1'b0, reset = 1'b1;
  logic io_in_valid = 1'b0, io_in_ready, io_rtp_finish = 1'b0;
  logic [31:0] io_in_ray_id = '0, io_in_hitT = '0, io_in_tri_id = '0;
  logic io_out_valid, io_out_ready = 1'b1, io_out_last, io_done;
  logic [IDW-1:0] io_out_ray_id;
  logic [31:0] io_out_hitT, io_out_tri_id, io_hit_count, io_drop_count;
  logic [63:0] io_cycles;
  logic [31:0] exp_h [N];
  logic [31:0] exp_t [N];
  int exp_hits, exp_drops, cyc, n_chk = 0, n_err = 0;
  hit_result_collector dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_ray_id(io_in_ray_id), .io_in_hitT(io_in_hitT), .io_in_tri_id(io_in_tri_id),
    .io_rtp_finish(io_rtp_finish),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_ray_id(io_out_ray_id), .io_out_hitT(io_out_hitT), .io_out_tri_id(io_out_tri_id),
    .io_out_last(io_out_last), .io_hit_count(io_hit_count), .io_drop_count(io_drop_count),
    .io_cycles(io_cycles), .io_done(io_done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_rtp_finish = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
    exp_hits = 0;
    exp_drops = 0;
    for (int i = 0; i < N; i++) begin
      exp_h[i] = 32'h7F800000;
      exp_t[i] = 32'hFFFFFFFF;
    end
    chk("rst_ready", io_in_ready, 0);
    chk("rst_out", {io_out_valid, io_out_last, io_out_ray_id, io_out_hitT, io_out_tri_id, io_done}, 0);
    chk("rst_cnt", {io_hit_count, io_drop_count, io_cycles}, 0);
  endtask
  task automatic wait_ready();
    repeat (N-1) step();
    chk("clear_ready_lo", io_in_ready, 0);
    step();
    chk("clear_ready_hi", io_in_ready, 1);
  endtask
  task automatic send(input logic [31:0] id, input logic [31:0] h, input logic [31:0] t);
    io_in_valid = 1'b1;
    io_in_ray_id = id;
    io_in_hitT = h;
    io_in_tri_id = t;
    if (io_in_ready) begin
      if (id >= N || h[31]) exp_drops++;
      else begin
        exp_hits++;
        if (h < exp_h[id]) begin
          exp_h[id] = h;
          exp_t[id] = t;
        end
      end
    end
    step();
    io_in_valid = 1'b0;
  endtask
  task automatic drain(input bit tog, input int f);
    int idx = 0;
    bit held = 0, rdy;
    logic [74:0] cur, hv, ev;
    for (int k = 0; k < 4*N + 50; k++) begin
      if (io_done) break;
      rdy = tog ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      cur = {io_out_last, io_out_ray_id, io_out_hitT, io_out_tri_id};
      if (held) chk("hold", {io_out_valid, cur}, {1'b1, hv});
      held = 0;
      if (io_out_valid) begin
        if (rdy) begin
          ev = {idx == N-1, IDW'(idx), exp_h[idx % N], exp_t[idx % N]};
          chk($sformatf("entry%0d", idx), cur, ev);
          if (!tog && idx == 0) chk("first_lat", cyc, f+4);
          if (!tog && idx == N-1) chk("last_lat", cyc, f+3+N);
          idx++;
        end else begin
          held = 1;
          hv = cur;
        end
      end
      io_out_ready = rdy;
      step();
    end
    io_out_ready = 1'b1;
    chk("drained", idx, N);
    chk("done", io_done, 1);
    chk("done_valid", io_out_valid, 0);
    if (!tog) chk("done_lat", cyc, f+4+N);
  endtask
  task automatic finish_drain(input bit tog, input bit with_rep);
    int f = cyc;
    io_rtp_finish = 1'b1;
    if (with_rep) send(2, 32'h3E800000, 55);
    else step();
    io_rtp_finish = 1'b0;
    chk("flush_ready", io_in_ready, 0);
    chk("cycles", io_cycles, f-N+1);
    chk("hits", io_hit_count, exp_hits);
    chk("drops", io_drop_count, exp_drops);
    drain(tog, f);
  endtask
  initial begin
    logic [31:0] id, h;
    do_reset();
    wait_ready();
    step();
    send(N, 32'h3F800000, 1);
    send(3, 32'hBF800000, 2);
    step();
    step();
    chk("drop2", io_drop_count, 2);
    chk("hit0", io_hit_count, 0);
    finish_drain(0, 0);
    do_reset();
    wait_ready();
    send(5, 32'h40400000, 7);
    send(5, 32'h3F800000, 9);
    send(5, 32'h40000000, 4);
    chk("hit3", io_hit_count, 3);
    send(8, 32'h3F800000, 1);
    send(8, 32'h3F800000, 2);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      else begin
        id = $urandom_range(0, 9) == 0 ? N + $urandom_range(0, 5000) : $urandom_range(0, 15);
        h = 32'h3F800000 + $urandom_range(0, 8) * 32'h00100000;
        if ($urandom_range(0, 9) == 0) h[31] = 1'b1;
        send(id, h, $urandom);
      end
    end
    finish_drain(1, 1);
    do_reset();
    wait_ready();
    for (int i = 0; i < 50; i++) send($urandom_range(0, 31), $urandom_range(0, 32'h7F000000), $urandom);
    io_rtp_finish = 1'b1;
    step();
    io_rtp_finish = 1'b0;
    repeat (100) step();
    chk("mid_drain_valid", io_out_valid, 1);
    do_reset();
    wait_ready();
    finish_drain(0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
